// File: rtl/axi_link_pair.sv
// axi_link_pair: AXI-style master/slave pair around a 256x8 memory; ports: clk/rst, en/en_ strobes, AR*/AW*/INDATA/LAST requests, all channel signals, OUT/BOUT observation.
module axi_link_pair #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        en_,
  input  logic        LAST,
  input  logic [7:0]  ARADDR,
  input  logic [3:0]  ARLEN,
  input  logic [3:0]  ARID,
  input  logic [7:0]  AWADDR,
  input  logic [3:0]  AWID,
  input  logic [7:0]  INDATA,
  output logic        ARVALID,
  output logic        ARREADY,
  output logic        RVALID,
  output logic        RREADY,
  output logic        RLAST,
  output logic [7:0]  RDATA,
  output logic        RRESP,
  output logic        AWVALID,
  output logic        AWREADY,
  output logic [11:0] AWOUT,
  output logic        WVALID,
  output logic        WREADY,
  output logic        WLAST,
  output logic [7:0]  WDATA,
  output logic        BVALID,
  output logic        BREADY,
  output logic [4:0]  BRESP,
  output logic [15:0] OUT,
  output logic [4:0]  BOUT
);
  typedef enum logic [1:0] {W_IDLE, W_AW, W_W, W_B} wr_t;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} rd_t;
  logic [7:0] mem [DEPTH];
  wr_t wr_q, wr_d;
  rd_t rd_q, rd_d;
  logic [7:0] awaddr_q, awaddr_d, indata_q, indata_d, wdata_q, wdata_d;
  logic [3:0] awid_q, awid_d;
  logic last_q, last_d, wlast_q, wlast_d, awready_q, awready_d, wready_q, wready_d;
  logic bvalid_q, bvalid_d;
  logic [4:0] bresp_q, bresp_d, bout_q, bout_d;
  logic [7:0] araddr_q, araddr_d, rdata_q, rdata_d, raddr;
  logic [3:0] arlen_q, arlen_d, arid_q, arid_d, beat_q, beat_d, nm1;
  logic arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [15:0] out_q, out_d;
  logic cap, rcap, aw_hs, w_hs, b_hs, ar_hs, r_hs, rnext;
  assign AWVALID = wr_q == W_AW;
  assign WVALID = wr_q == W_W;
  assign BREADY = wr_q == W_B;
  assign ARVALID = rd_q == R_AR;
  assign RREADY = rd_q == R_R;
  assign aw_hs = AWVALID && awready_q;
  assign w_hs = WVALID && wready_q;
  assign b_hs = BREADY && bvalid_q;
  assign ar_hs = ARVALID && arready_q;
  assign r_hs = RREADY && rvalid_q;
  assign AWREADY = awready_q;
  assign WREADY = wready_q;
  assign ARREADY = arready_q;
  assign AWOUT = {awid_q, awaddr_q};
  assign WDATA = wdata_q;
  assign WLAST = wlast_q;
  assign BVALID = bvalid_q;
  assign BRESP = bresp_q;
  assign BOUT = bout_q;
  assign RVALID = rvalid_q;
  assign RLAST = rlast_q;
  assign RDATA = rdata_q;
  assign RRESP = 1'b0;
  assign OUT = out_q;
  always_comb begin
    cap = en_ && wr_q == W_IDLE;
    wr_d = cap ? W_AW : aw_hs ? W_W : w_hs ? (wlast_q ? W_B : W_IDLE) : b_hs ? W_IDLE : wr_q;
    awaddr_d = cap ? AWADDR : awaddr_q;
    awid_d = cap ? AWID : awid_q;
    indata_d = cap ? INDATA : indata_q;
    last_d = cap ? LAST : last_q;
    wdata_d = aw_hs ? indata_q : wdata_q;
    wlast_d = aw_hs ? last_q : w_hs ? 1'b0 : wlast_q;
    // slave READYs pulse high one cycle after VALID is seen, dropping right after the transfer
    awready_d = AWVALID && !awready_q;
    wready_d = WVALID && !wready_q;
    arready_d = ARVALID && !arready_q;
    bvalid_d = w_hs && wlast_q ? 1'b1 : b_hs ? 1'b0 : bvalid_q;
    bresp_d = w_hs && wlast_q ? {awid_q, 1'b0} : bresp_q;
    bout_d = b_hs ? bresp_q : bout_q;
    rcap = en && rd_q == R_IDLE;
    rd_d = rcap ? R_AR : ar_hs ? R_R : r_hs && rlast_q ? R_IDLE : rd_q;
    araddr_d = rcap ? ARADDR : araddr_q;
    arlen_d = rcap ? ARLEN : arlen_q;
    arid_d = rcap ? ARID : arid_q;
    nm1 = arlen_q == 4'd0 ? 4'd0 : arlen_q - 4'd1;
    rnext = r_hs && !rlast_q;
    beat_d = ar_hs ? 4'd0 : rnext ? beat_q + 4'd1 : beat_q;
    // 8-bit sum wraps 0xFF -> 0x00 naturally
    raddr = araddr_q + {4'd0, beat_d};
    rdata_d = ar_hs || rnext ? mem[raddr] : rdata_q;
    rvalid_d = ar_hs ? 1'b1 : r_hs && rlast_q ? 1'b0 : rvalid_q;
    rlast_d = ar_hs || rnext ? beat_d == nm1 : r_hs ? 1'b0 : rlast_q;
    out_d = r_hs ? {arid_q, arlen_q, rdata_q} : out_q;
  end
  always_ff @(posedge clk)
    if (!rst && w_hs) mem[awaddr_q] <= wdata_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= W_IDLE;
      rd_q <= R_IDLE;
      awaddr_q <= '0;
      awid_q <= '0;
      indata_q <= '0;
      last_q <= 1'b0;
      wdata_q <= '0;
      wlast_q <= 1'b0;
      awready_q <= 1'b0;
      wready_q <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q <= '0;
      bout_q <= '0;
      araddr_q <= '0;
      arlen_q <= '0;
      arid_q <= '0;
      beat_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
      rlast_q <= 1'b0;
      out_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      awaddr_q <= awaddr_d;
      awid_q <= awid_d;
      indata_q <= indata_d;
      last_q <= last_d;
      wdata_q <= wdata_d;
      wlast_q <= wlast_d;
      awready_q <= awready_d;
      wready_q <= wready_d;
      arready_q <= arready_d;
      bvalid_q <= bvalid_d;
      bresp_q <= bresp_d;
      bout_q <= bout_d;
      araddr_q <= araddr_d;
      arlen_q <= arlen_d;
      arid_q <= arid_d;
      beat_q <= beat_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q <= rlast_d;
      out_q <= out_d;
    end
  end
endmodule

// File: tb/tb_axi_link_pair.sv
// tb_axi_link_pair: directed self-checking bench for axi_link_pair
module tb_axi_link_pair;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, en_ = 1'b0, LAST = 1'b0;
  logic [7:0] ARADDR = '0, AWADDR = '0, INDATA = '0;
  logic [3:0] ARLEN = '0, ARID = '0, AWID = '0;
  logic ARVALID, ARREADY, RVALID, RREADY, RLAST, RRESP;
  logic AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic [7:0] RDATA, WDATA;
  logic [11:0] AWOUT;
  logic [4:0] BRESP, BOUT;
  logic [15:0] OUT;
  int n_cmp = 0, n_err = 0;
  axi_link_pair dut (
    .clk(clk), .rst(rst), .en(en), .en_(en_), .LAST(LAST),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARID(ARID),
    .AWADDR(AWADDR), .AWID(AWID), .INDATA(INDATA),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .RVALID(RVALID), .RREADY(RREADY),
    .RLAST(RLAST), .RDATA(RDATA), .RRESP(RRESP),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWOUT(AWOUT),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WDATA(WDATA),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .OUT(OUT), .BOUT(BOUT)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic [3:0] id,
                          input logic last, input logic dup);
    AWADDR = a; AWID = id; INDATA = d; LAST = last; en_ = 1'b1;
    tick;
    en_ = 1'b0;
    chk("awvalid_n1", AWVALID, 1); chk("awready_n1", AWREADY, 0); chk("awout", AWOUT, {id, a});
    tick;
    chk("awready_n2", AWREADY, 1); chk("awvalid_n2", AWVALID, 1);
    tick;
    chk("awvalid_done", AWVALID, 0); chk("wvalid_n3", WVALID, 1); chk("wdata", WDATA, d);
    chk("wlast", WLAST, last); chk("awready_drop", AWREADY, 0); chk("wready_n3", WREADY, 0);
    if (dup) begin
      AWADDR = a ^ 8'h55; en_ = 1'b1;
    end
    tick;
    en_ = 1'b0; AWADDR = a;
    chk("wready_n4", WREADY, 1);
    tick;
    chk("wvalid_done", WVALID, 0); chk("bvalid", BVALID, last); chk("bready", BREADY, last);
    if (last) begin
      chk("bresp", BRESP, {id, 1'b0});
      tick;
      chk("bout", BOUT, {id, 1'b0}); chk("bvalid_done", BVALID, 0); chk("bready_done", BREADY, 0);
    end
    tick;
    chk("awvalid_idle", AWVALID, 0); chk("awout_hold", AWOUT, {id, a});
  endtask
  task automatic do_read(input logic [7:0] a, input logic [3:0] l, input logic [3:0] id,
                         input logic [31:0] ex);
    int n;
    n = (l == 4'd0) ? 1 : int'(l);
    ARADDR = a; ARLEN = l; ARID = id; en = 1'b1;
    tick;
    en = 1'b0;
    chk("arvalid", ARVALID, 1); chk("arready0", ARREADY, 0);
    tick;
    chk("arready1", ARREADY, 1);
    tick;
    chk("arvalid_done", ARVALID, 0);
    for (int k = 0; k < n; k++) begin
      chk("rvalid", RVALID, 1); chk("rready", RREADY, 1); chk("rresp", RRESP, 0);
      chk("rdata", RDATA, ex[8*k +: 8]); chk("rlast", RLAST, k == n - 1);
      tick;
      chk("out", OUT, {id, l, ex[8*k +: 8]});
    end
    chk("rvalid_end", RVALID, 0); chk("rready_end", RREADY, 0); chk("rlast_end", RLAST, 0);
  endtask
  initial begin
    tick; tick;
    rst = 1'b0;
    chk("rst_awvalid", AWVALID, 0); chk("rst_arvalid", ARVALID, 0); chk("rst_out", OUT, 0);
    chk("rst_bout", BOUT, 0); chk("rst_awout", AWOUT, 0); chk("rst_rvalid", RVALID, 0);
    do_write(8'h01, 8'h01, 4'h1, 1'b0, 1'b0);
    do_write(8'h02, 8'h02, 4'h1, 1'b0, 1'b1);
    do_write(8'h03, 8'h03, 4'h1, 1'b1, 1'b0);
    chk("bout_final", BOUT, 16'h0002);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst2_bout", BOUT, 0);
    do_read(8'h01, 4'd3, 4'h1, 32'h0003_0201);
    chk("out_final", OUT, 16'h1303);
    do_write(8'hFF, 8'hAB, 4'h2, 1'b0, 1'b0);
    do_write(8'h00, 8'hCD, 4'h2, 1'b0, 1'b0);
    do_read(8'hFF, 4'd0, 4'h4, 32'h0000_00AB);
    do_read(8'hFF, 4'd2, 4'h5, 32'h0000_CDAB);
    do_read(8'h02, 4'd1, 4'h6, 32'h0000_0002);
    ARADDR = 8'h01; ARLEN = 4'd3; ARID = 4'h7; en = 1'b1;
    tick;
    en = 1'b0;
    tick; tick; tick;
    chk("mid_rvalid", RVALID, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_rvalid", RVALID, 0); chk("abort_rready", RREADY, 0); chk("abort_arvalid", ARVALID, 0);
    do_read(8'h01, 4'd2, 4'h3, 32'h0000_0201);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
